toy_bus_ddec_node_param: RTL and testbench

Parametrised, registered target-id decode node for the toy bus request channel. One request input fans out to N_OUT output channels. The route is chosen per tgt_id from a parameter lookup table. A two-entry skid buffer gives full throughput with registered in_rdy. Sits between a bus master port and downstream arbiter nodes; replaces purely combinational decode nodes where timing closure or fan-out needs a pipeline stage.

---
 rtl/toy_bus_ddec_node_param.sv | 185 ++++++++++++++++++
 tb/tb_toy_bus_ddec_node_param.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/toy_bus_ddec_node_param.sv
// toy_bus_ddec_node_param
// Registered target-id decode node for the toy bus request channel.
// One request input is routed to one of N_OUT output channels. The channel
// comes from the RTE_MAP lookup table, indexed by tgt_id. An output register
// (OR) and a skid register (SK) keep full throughput while in0_rdy stays a
// flop output.
// Requests whose table entry is >= N_OUT are consumed and counted as drops.
// Optional build macro: TOY_BUS_DDEC_DEFAULT_ROUTE_EN. When it is defined,
// unmapped requests are sent to channel DEFAULT_CH instead of being dropped,
// and they are still flagged on err_pulse/err_cnt.
module toy_bus_ddec_node_param #(
  parameter int N_OUT     = 2,
  parameter int ADDR_W    = 32,
  parameter int STRB_W    = 32,
  parameter int DATA_W    = 256,
  parameter int TGT_W     = 4,
  parameter int SB_W      = 32,
  parameter logic [8*(1<<TGT_W)-1:0] RTE_MAP = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FF01_0100_FFFF,
  parameter int ERR_CNT_W = 16
`ifdef TOY_BUS_DDEC_DEFAULT_ROUTE_EN
  ,
  parameter int DEFAULT_CH = 0
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in0_vld,
  output logic                 in0_rdy,
  input  logic [ADDR_W-1:0]    in0_addr,
  input  logic [STRB_W-1:0]    in0_strb,
  input  logic [DATA_W-1:0]    in0_data,
  input  logic                 in0_opcode,
  input  logic [TGT_W-1:0]     in0_src_id,
  input  logic [TGT_W-1:0]     in0_tgt_id,
  input  logic [SB_W-1:0]      in0_sideband,
  output logic [N_OUT-1:0]     out_vld,
  input  logic [N_OUT-1:0]     out_rdy,
  output logic [ADDR_W-1:0]    out_addr,
  output logic [STRB_W-1:0]    out_strb,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_opcode,
  output logic [TGT_W-1:0]     out_src_id,
  output logic [TGT_W-1:0]     out_tgt_id,
  output logic [SB_W-1:0]      out_sideband,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [TGT_W-1:0]     err_tgt_id
);

  // Width of the packed request payload carried through OR and SK.
  localparam int PW = ADDR_W + STRB_W + DATA_W + 1 + 2*TGT_W + SB_W;
  localparam logic [7:0] N_OUT_B = 8'(N_OUT);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

  // Decode results for the current input beat.
  logic [7:0]       ch_s;
  logic             hit_s;
  logic             route_s;
  logic             err_s;
  logic [N_OUT-1:0] sel_s;
  logic [PW-1:0]    in_pl_s;
  logic             acc_s;

  // Storage: the one-hot select doubles as the valid flag (all-zero = empty).
  logic [N_OUT-1:0] or_sel_r, or_sel_n_s;
  logic [PW-1:0]    or_pl_r,  or_pl_n_s;
  logic [N_OUT-1:0] sk_sel_r, sk_sel_n_s;
  logic [PW-1:0]    sk_pl_r,  sk_pl_n_s;
  logic             or_vld_s;
  logic             sk_vld_s;
  logic             drain_s;
  logic             rdy_r;

  // Error reporting registers.
  logic                 err_pulse_r;
  logic [ERR_CNT_W-1:0] err_cnt_r;
  logic [TGT_W-1:0]     err_tgt_r;

  assign in_pl_s  = {in0_addr, in0_strb, in0_data, in0_opcode, in0_src_id, in0_tgt_id, in0_sideband};
  assign acc_s    = in0_vld && rdy_r;
  assign or_vld_s = |or_sel_r;
  assign sk_vld_s = |sk_sel_r;
  assign drain_s  = |(or_sel_r & out_rdy);

  // Look up the route for the incoming tgt_id and form the one-hot channel select.
  always_comb begin
    ch_s  = RTE_MAP[{in0_tgt_id, 3'b000} +: 8];
    hit_s = (ch_s < N_OUT_B);
    sel_s = '0;
    for (int i = 0; i < N_OUT; i++) begin
      sel_s[i] = hit_s && (ch_s == 8'(i));
    end
`ifdef TOY_BUS_DDEC_DEFAULT_ROUTE_EN
    // Fallback: unmapped traffic goes to DEFAULT_CH but is still flagged.
    if (!hit_s) begin
      for (int i = 0; i < N_OUT; i++) begin
        sel_s[i] = (i == DEFAULT_CH);
      end
    end else begin
      sel_s = sel_s;
    end
    route_s = 1'b1;
    err_s   = !hit_s;
`else
    route_s = hit_s;
    err_s   = !hit_s;
`endif
  end

  // Next-state for OR/SK: the skid entry refills OR first; an input goes to OR only when OR is free.
  always_comb begin
    or_sel_n_s = or_sel_r;
    or_pl_n_s  = or_pl_r;
    sk_sel_n_s = sk_sel_r;
    sk_pl_n_s  = sk_pl_r;
    if (drain_s) begin
      if (sk_vld_s) begin
        // in0_rdy is low while SK is full, so no input can arrive here.
        or_sel_n_s = sk_sel_r;
        or_pl_n_s  = sk_pl_r;
        sk_sel_n_s = '0;
      end else if (acc_s && route_s) begin
        or_sel_n_s = sel_s;
        or_pl_n_s  = in_pl_s;
      end else begin
        // Payload is left as-is; it is don't-care while out_vld is low.
        or_sel_n_s = '0;
      end
    end else if (acc_s && route_s) begin
      if (!or_vld_s) begin
        or_sel_n_s = sel_s;
        or_pl_n_s  = in_pl_s;
      end else begin
        sk_sel_n_s = sel_s;
        sk_pl_n_s  = in_pl_s;
      end
    end else begin
      or_sel_n_s = or_sel_r;
    end
  end

  // Datapath registers and the registered ready (ready whenever SK will be empty).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_sel_r <= '0;
      or_pl_r  <= '0;
      sk_sel_r <= '0;
      sk_pl_r  <= '0;
      rdy_r    <= 1'b0;
    end else begin
      or_sel_r <= or_sel_n_s;
      or_pl_r  <= or_pl_n_s;
      sk_sel_r <= sk_sel_n_s;
      sk_pl_r  <= sk_pl_n_s;
      rdy_r    <= ~(|sk_sel_n_s);
    end
  end

  // Flag unmapped accepts: one-cycle pulse, saturating count, last offending tgt_id.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse_r <= 1'b0;
      err_cnt_r   <= '0;
      err_tgt_r   <= '0;
    end else if (acc_s && err_s) begin
      err_pulse_r <= 1'b1;
      err_tgt_r   <= in0_tgt_id;
      if (err_cnt_r != CNT_MAX) begin
        err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end else begin
      err_pulse_r <= 1'b0;
    end
  end

  assign in0_rdy    = rdy_r;
  assign out_vld    = or_sel_r;
  assign {out_addr, out_strb, out_data, out_opcode, out_src_id, out_tgt_id, out_sideband} = or_pl_r;
  assign err_pulse  = err_pulse_r;
  assign err_cnt    = err_cnt_r;
  assign err_tgt_id = err_tgt_r;

endmodule

// File: tb/tb_toy_bus_ddec_node_param.sv
// Self-checking bench for toy_bus_ddec_node_param (ERR_CNT_W=2 to reach saturation quickly).
module tb_toy_bus_ddec_node_param;
  localparam int N_OUT = 2, ADDR_W = 32, STRB_W = 32, DATA_W = 256, TGT_W = 4, SB_W = 32, ERR_CNT_W = 2;

  logic clk, rst_n, in0_vld, in0_rdy, in0_opcode, out_opcode, err_pulse;
  logic [ADDR_W-1:0] in0_addr, out_addr;
  logic [STRB_W-1:0] in0_strb, out_strb;
  logic [DATA_W-1:0] in0_data, out_data;
  logic [TGT_W-1:0]  in0_src_id, in0_tgt_id, out_src_id, out_tgt_id, err_tgt_id;
  logic [SB_W-1:0]   in0_sideband, out_sideband;
  logic [N_OUT-1:0]  out_vld, out_rdy;
  logic [ERR_CNT_W-1:0] err_cnt;

  toy_bus_ddec_node_param #(
    .N_OUT(N_OUT), .ADDR_W(ADDR_W), .STRB_W(STRB_W), .DATA_W(DATA_W), .TGT_W(TGT_W),
    .SB_W(SB_W), .ERR_CNT_W(ERR_CNT_W)
`ifdef TOY_BUS_DDEC_DEFAULT_ROUTE_EN
    , .DEFAULT_CH(1)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .in0_vld(in0_vld), .in0_rdy(in0_rdy),
    .in0_addr(in0_addr), .in0_strb(in0_strb), .in0_data(in0_data), .in0_opcode(in0_opcode),
    .in0_src_id(in0_src_id), .in0_tgt_id(in0_tgt_id), .in0_sideband(in0_sideband),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_addr(out_addr), .out_strb(out_strb),
    .out_data(out_data), .out_opcode(out_opcode), .out_src_id(out_src_id),
    .out_tgt_id(out_tgt_id), .out_sideband(out_sideband),
    .err_pulse(err_pulse), .err_cnt(err_cnt), .err_tgt_id(err_tgt_id)
  );

  typedef struct { logic [1:0] vld; logic [511:0] pl; } exp_t;
  exp_t q[$];
  int   hs_cyc[$];
  int   errors = 0, checks = 0, cyc = 0;
  logic exp_pulse = 1'b0;
  logic [1:0] exp_cnt = 2'd0;
  logic [3:0] exp_tgt = 4'd0;

`ifdef TOY_BUS_DDEC_DEFAULT_ROUTE_EN
  localparam logic [1:0] UNMAPPED_VLD = 2'b10;
`else
  localparam logic [1:0] UNMAPPED_VLD = 2'b00;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference route table: tgt 2 -> ch0, tgt 3,4 -> ch1, everything else unmapped.
  function automatic int route(input int tgt);
    case (tgt)
      2:       return 0;
      3, 4:    return 1;
`ifdef TOY_BUS_DDEC_DEFAULT_ROUTE_EN
      default: return 1;
`else
      default: return -1;
`endif
    endcase
  endfunction

  function automatic logic [511:0] pack(input logic [31:0] a, input logic [31:0] s,
      input logic [255:0] d, input logic o, input logic [3:0] si, input logic [3:0] t,
      input logic [31:0] sb);
    return 512'({a, s, d, o, si, t, sb});
  endfunction

  // Drive one request and wait (bounded) for acceptance; record expectations on accept.
  task automatic send(input int tgt);
    bit acc = 1'b0;
    exp_t e;
    in0_addr     = $urandom;
    in0_strb     = $urandom;
    in0_data     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    in0_opcode   = 1'($urandom_range(0, 1));
    in0_src_id   = 4'($urandom_range(0, 15));
    in0_tgt_id   = 4'(tgt);
    in0_sideband = $urandom;
    in0_vld      = 1'b1;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = in0_rdy;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      chk("send_timeout", 512'd0, 512'd1);
    end else begin
      if (route(tgt) >= 0) begin
        e.vld = 2'b01 << route(tgt);
        e.pl  = pack(in0_addr, in0_strb, in0_data, in0_opcode, in0_src_id, in0_tgt_id, in0_sideband);
        q.push_back(e);
      end
      if (!(tgt inside {2, 3, 4})) begin
        exp_pulse = 1'b1;
        exp_tgt   = 4'(tgt);
        if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
      end
    end
    in0_vld = 1'b0;
  endtask

  task automatic wait_empty();
    for (int k = 0; k < 300 && q.size() > 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_timeout", 512'(q.size()), 512'd0);
  endtask

  // Monitor: error outputs every cycle; output beats against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("err_pulse", 512'(err_pulse), 512'(exp_pulse));
      exp_pulse = 1'b0;
      chk("err_cnt", 512'(err_cnt), 512'(exp_cnt));
      chk("err_tgt_id", 512'(err_tgt_id), 512'(exp_tgt));
      if (out_vld != 2'b00) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 512'(out_vld), 512'd0);
        end else begin
          chk("out_vld", 512'(out_vld), 512'(q[0].vld));
          chk("payload", pack(out_addr, out_strb, out_data, out_opcode, out_src_id, out_tgt_id,
                              out_sideband), q[0].pl);
          if ((out_vld & out_rdy) != 2'b00) begin
            void'(q.pop_front());
            hs_cyc.push_back(cyc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    rst_n = 1'b0; in0_vld = 1'b1; in0_tgt_id = 4'd2; out_rdy = 2'b00;
    in0_addr = '0; in0_strb = '0; in0_data = '0; in0_opcode = 1'b0;
    in0_src_id = '0; in0_sideband = '0;
    repeat (3) @(negedge clk);
    chk("reset_out_vld", 512'(out_vld), 512'd0);
    chk("reset_in0_rdy", 512'(in0_rdy), 512'd0);
    chk("reset_err_cnt", 512'(err_cnt), 512'd0);
    chk("reset_err_pulse", 512'(err_pulse), 512'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; in0_vld = 1'b0;
    @(negedge clk);
    chk("rdy_before_edge", 512'(in0_rdy), 512'd0);
    @(negedge clk);
    chk("rdy_after_edge", 512'(in0_rdy), 512'd1);

    // Routing, back-to-back with both readies high: no bubbles.
    @(posedge clk); #1; out_rdy = 2'b11;
    base = hs_cyc.size();
    send(2); send(3); send(4);
    wait_empty();
    chk("rt_hs_count", 512'(hs_cyc.size() - base), 512'd3);
    if (hs_cyc.size() - base == 3) begin
      for (int i = 0; i < 2; i++) chk("rt_no_bubble", 512'(hs_cyc[base+i+1] - hs_cyc[base+i]), 512'd1);
    end

    // Backpressure: two accepted, third stalls until ch0 drains.
    out_rdy = 2'b00;
    send(2); send(2);
    fork
      send(2);
      begin
        @(negedge clk);
        chk("bp_full", 512'(in0_rdy), 512'd0);
        repeat (3) begin
          @(negedge clk);
          chk("bp_full_hold", 512'(in0_rdy), 512'd0);
        end
        @(posedge clk); #1;
        out_rdy = 2'b01;
      end
    join
    wait_empty();
    @(negedge clk);
    chk("bp_recover", 512'(in0_rdy), 512'd1);

    // Drop of an unmapped target, then saturation of the 2-bit counter.
    @(posedge clk); #1; out_rdy = 2'b11;
    send(7);
    @(negedge clk);
    chk("drop_pulse", 512'(err_pulse), 512'd1);
    chk("drop_tgt", 512'(err_tgt_id), 512'd7);
    chk("drop_cnt", 512'(err_cnt), 512'd1);
    chk("drop_out_vld", 512'(out_vld), 512'(UNMAPPED_VLD));
    @(negedge clk);
    chk("drop_pulse_end", 512'(err_pulse), 512'd0);
    @(posedge clk); #1;
    repeat (5) send(7);
    @(negedge clk);
    chk("drop_sat", 512'(err_cnt), 512'd3);
    wait_empty();

    // Wrong-channel ready: head on ch1 held while only ch0 is ready.
    @(posedge clk); #1; out_rdy = 2'b01;
    send(3);
    base = hs_cyc.size();
    repeat (10) begin
      @(negedge clk);
      chk("wc_hold_vld", 512'(out_vld), 512'd2);
    end
    chk("wc_no_hs", 512'(hs_cyc.size() - base), 512'd0);
    @(posedge clk); #1;
    send(7);
    @(negedge clk);
    chk("wc_hold_after_drop", 512'(out_vld), 512'd2);
    @(posedge clk); #1; out_rdy = 2'b10;
    wait_empty();

    // tgt 9: dropped by default, routed to ch1 with the fallback build.
    @(posedge clk); #1; out_rdy = 2'b11;
    send(9);
    @(negedge clk);
    chk("dflt_vld", 512'(out_vld), 512'(UNMAPPED_VLD));
    chk("dflt_err", 512'(err_pulse), 512'd1);
    wait_empty();

    // Random mix with random readies.
    @(posedge clk); #1;
    fork
      for (int i = 0; i < 20; i++) send(int'($urandom_range(0, 15)));
      repeat (60) begin
        @(posedge clk); #1;
        out_rdy = 2'($urandom_range(0, 3));
      end
    join
    out_rdy = 2'b11;
    wait_empty();
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
